// File: rtl/mdu_multicycle_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM states and the divide-class helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5,
    MDU_MSUB  = 3'd6,
    MDU_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_multicycle_if.sv
// Handshake and data bundle between the E stage and the multiply/divide unit.
interface mdu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mdu_multicycle_result_calc.sv
// Combinational 2*WIDTH result for every MDU op, including the
// divide-by-zero rule and HI/LO accumulation for madd/msub.
module mdu_result_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_result
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_dividend;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_q_fin;
  logic [WIDTH-1:0]   w_r_fin;

  // Sign-extending to 2*WIDTH makes the truncated product the correct signed result.
  assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_acc    = {i_hi, i_lo};

  // Signed division runs on magnitudes; MIN/-1 falls out as MIN with remainder 0.
  assign w_div_signed = (i_op == MDU_DIV);
  assign w_a_neg      = w_div_signed & i_a[WIDTH-1];
  assign w_b_neg      = w_div_signed & i_b[WIDTH-1];
  assign w_dividend   = w_a_neg ? (~i_a + ONE) : i_a;
  assign w_divisor    = (i_b == {WIDTH{1'b0}}) ? ONE : (w_b_neg ? (~i_b + ONE) : i_b);
  assign w_q          = w_dividend / w_divisor;
  assign w_r          = w_dividend % w_divisor;
  assign w_q_fin      = (w_a_neg ^ w_b_neg) ? (~w_q + ONE) : w_q;
  assign w_r_fin      = w_a_neg ? (~w_r + ONE) : w_r;

  // Result select per op.
  always_comb begin
    o_result = {(2*WIDTH){1'b0}};
    case (mdu_op_e'(i_op))
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (i_b == {WIDTH{1'b0}}) begin
          o_result = {i_a, {WIDTH{1'b1}}};
        end else begin
          o_result = {w_r_fin, w_q_fin};
        end
      end
      MDU_MADD:  o_result = w_acc + w_prod_s;
      MDU_MADDU: o_result = w_acc + w_prod_u;
      MDU_MSUB:  o_result = w_acc - w_prod_s;
      MDU_MSUBU: o_result = w_acc - w_prod_u;
      default:   o_result = {(2*WIDTH){1'b0}};
    endcase
  end

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit: owns HI/LO, runs a per-class latency
// counter, supports mthi/mtlo and pipeline-flush abort.
module mdu_multicycle
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  mdu_multicycle_if.slave    bus
);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_lat;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               w_launch;
  logic               w_commit;
  logic               w_mt_hi;
  logic               w_mt_lo;
  logic [2*WIDTH-1:0] w_result;

  assign w_lat = mdu_is_div(mdu_op_e'(bus.op)) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  // Result is evaluated against the live HI/LO, which cannot change while busy.
  mdu_result_calc #(.WIDTH(WIDTH)) u_calc (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

  // Next-state, counter and write-enable decode; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = w_lat;
          end else begin
            w_mt_hi = bus.mthi;
            w_mt_lo = bus.mtlo;
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, latency counter and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_commit;
    end
  end

  // Pending operands captured at launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= 3'd0;
      r_a  <= {WIDTH{1'b0}};
      r_b  <= {WIDTH{1'b0}};
    end else if (w_launch) begin
      r_op <= bus.op;
      r_a  <= bus.a;
      r_b  <= bus.b;
    end
  end

  // HI/LO: commit or architectural move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (w_commit) begin
      {r_hi, r_lo} <= w_result;
    end else begin
      if (w_mt_hi) r_hi <= bus.a;
      if (w_mt_lo) r_lo <= bus.a;
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = (r_state == ST_BUSY);
  assign bus.done = r_done;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed self-checking bench for mdu_multicycle.
module tb_mdu_multicycle;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mdu_multicycle_if #(.WIDTH(32)) bus ();

  mdu_multicycle #(
    .WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic mt(input logic to_hi, input logic [31:0] v);
    @(negedge clk);
    bus.mthi = to_hi;
    bus.mtlo = ~to_hi;
    bus.a    = v;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
  endtask

  // Counts busy cycles (bounded) and done pulses up to 3 cycles after busy drops.
  task automatic wait_done(output int n, output int dn);
    n  = 0;
    dn = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (bus.done) dn++;
      @(negedge clk);
    end
    if (bus.done) dn++;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
  endtask

  task automatic test_reset();
    int dn;
    mt(1'b1, 32'h0000_0055);
    n_checks++;
    if (bus.hi !== 32'h0000_0055) begin
      n_fail++; $display("FAIL mthi: got %h want %h", bus.hi, 32'h0000_0055);
    end
    go(MDU_MULT, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: busy=%b hi=%h lo=%h done=%b want 0/0/0/0",
                         bus.busy, bus.hi, bus.lo, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    n_checks++;
    if (dn !== 0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_no_done: done_pulses=%0d lo=%h want 0/0", dn, bus.lo);
    end
  endtask

  task automatic test_mult();
    int n, dn;
    go(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(n, dn);
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL mult_busy: got %0d cycles want 5", n); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL mult_done: got %0d pulses want 1", dn); end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      n_fail++; $display("FAIL mult_val: got %h_%h want ffffffff_fffffff1", bus.hi, bus.lo);
    end
    go(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(n, dn);
    n_checks++;
    if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu_val: got %h_%h want 00000001_fffffffe", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int n, dn;
    go(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, dn);
    n_checks++;
    if (n !== 10) begin n_fail++; $display("FAIL div_busy: got %0d cycles want 10", n); end
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_val: got hi=%h lo=%h want ffffffff/fffffffd", bus.hi, bus.lo);
    end
    go(MDU_DIVU, 32'd7, 32'd0);
    wait_done(n, dn);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd7) begin
      n_fail++; $display("FAIL divu_zero: got hi=%h lo=%h want 00000007/ffffffff", bus.hi, bus.lo);
    end
  endtask

  task automatic test_madd_msub();
    int n, dn;
    mt(1'b1, 32'h0);
    mt(1'b0, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mthi_mtlo: got %h_%h want 00000000_ffffffff", bus.hi, bus.lo);
    end
    go(MDU_MADDU, 32'd1, 32'd1);
    wait_done(n, dn);
    n_checks++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
      n_fail++; $display("FAIL maddu_val: got %h_%h want 00000001_00000000", bus.hi, bus.lo);
    end
    go(MDU_MSUB, 32'd1, 32'd1);
    wait_done(n, dn);
    n_checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL msub_val: got %h_%h want 00000000_ffffffff", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_min();
    int n, dn;
    go(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, dn);
    n_checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      n_fail++; $display("FAIL div_min: got hi=%h lo=%h want 00000000/80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    int dn;
    go(MDU_MULT, 32'd2, 32'd2);
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    n_checks++;
    if (dn !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL flush_keep: done_pulses=%0d hi=%h lo=%h want 0/00000000/80000000",
                         dn, bus.hi, bus.lo);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    bus.op = MDU_MULT; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_start: busy got %b want 0", bus.busy);
    end
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    n_checks++;
    if (dn !== 0 || bus.lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL flush_start_keep: done_pulses=%0d lo=%h want 0/80000000", dn, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    int n, dn;
    go(MDU_MULT, 32'd2, 32'd3);
    bus.start = 1'b1;
    bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, dn);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL b2b_busy: got %0d remaining cycles want 4", n); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 1", dn); end
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      n_fail++; $display("FAIL b2b_val: got %h_%h want 00000000_00000006", bus.hi, bus.lo);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want 0/0/0/0",
                         bus.busy, bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_madd_msub();
    test_div_min();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
